mem_stage_wait_ctrl: RTL
========================

// Module: mem_stage_wait_ctrl
// PURPOSE
//  Pipelined MEM stage with built-in MEM->WB register for the ARM core, sitting after the EXE->MEM register.
//  Data memory has a parametrised access latency. While an access is in flight, the block drops 'ready'
//  to freeze IF..EXE/MEM registers and inserts a bubble into WB. Non-memory instructions pass in 1 cycle.
// PARAMETERS
//  DATA_W       32    data / address width
//  DEPTH        64    data memory size in words
//  BASE_ADDR    1024  byte address of word 0
//  WAIT_CYCLES  3     access wait states, legal range 1..15 (0 illegal)
// PORTS
//  clk              in   1       clock
//  rst              in   1       reset; one clock, synchronous, active-high
//  wb_en_in         in   1       write-back enable from EXE->MEM reg
//  mem_read_en_in   in   1       load request
//  mem_write_en_in  in   1       store request
//  alu_res_in       in   DATA_W  byte address (mem op) or ALU result (non-mem op)
//  val_rm_in        in   DATA_W  store data
//  dest_in          in   4       destination register
//  ready            out  1       1 = pipeline may advance; 0 = freeze all upstream regs (combinational)
//  addr_err         out  1       sticky: out-of-range/misaligned access seen since reset
//  wb_en_out        out  1       MEM->WB registered outputs
//  mem_read_en_out  out  1
//  alu_res_out      out  DATA_W
//  mem_data_out     out  DATA_W
//  dest_out         out  4
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0, addr_err 0, all *_out 0. Memory array not cleared.
//   Reset mid-access aborts the access; a pending store is not written.
//  Address: idx = (alu_res_in - BASE_ADDR) >> 2. Valid iff alu_res_in >= BASE_ADDR,
//   alu_res_in[1:0] == 0, and idx < DEPTH.
//   Invalid access: store dropped, load returns 0, addr_err set (cleared only by rst).
//  req = mem_read_en_in | mem_write_en_in. If both are set, the access is a store and mem_read_en_out = 0.
//  FSM states:
//   IDLE:
//    - req=0: ready=1; capture into MEM->WB reg at clock edge.
//    - req=1: ready=0; go to ACCESS; cnt <= WAIT_CYCLES-1.
//   ACCESS:
//    - ready=0; cnt decrements each cycle.
//    - At cnt==0: perform store, or latch load data into an internal buffer; go to DONE.
//   DONE:
//    - ready=1; MEM->WB reg captures the buffered load data; go to IDLE.
//  Latency: memory op = WAIT_CYCLES+2 cycles, ready high only in the last one. Non-mem op = 1 cycle.
//  Store commit: exactly once per instruction, on the final ACCESS edge.
//  Inputs: required stable while ready=0 (upstream frozen); the block does not re-sample them.
//  MEM->WB reg:
//   - Loads on every edge with ready=1.
//   - On edges with ready=0: wb_en_out <= 0 and mem_read_en_out <= 0 (bubble); data/dest hold.
//   - mem_data_out is 0 for non-load instructions.
//  Back-to-back: a mem op immediately after DONE re-enters ACCESS with no idle gap.
// TESTING (BASE_ADDR=1024, WAIT_CYCLES=3)
//  1. rst held 2 cycles mid-stream -> all outputs 0, ready=1, addr_err=0 next cycle.
//  2. Non-mem op: alu_res=0x55, dest=3, wb_en=1 -> next cycle alu_res_out=0x55, dest_out=3,
//     wb_en_out=1; ready stays 1.
//  3. Store 0xDEADBEEF @1032, then load @1032 -> each: ready low 4 cycles, then high 1;
//     load gives mem_data_out=0xDEADBEEF; wb_en_out=0 during stalls.
//  4. Store @1020 and load @1026 -> no memory change; load returns 0; addr_err=1 and stays 1.
//  5. Load @1284 (idx 65 >= DEPTH) -> returns 0, addr_err=1.
//     Store @1276 (idx 63) then read back -> data correct.
//  6. Store 0x1 @1028 with rst asserted in ACCESS cnt=1 -> word @1028 unchanged;
//     both-enables store @1028=0x7 -> written, mem_read_en_out=0.

Source files
------------

// File: rtl/mem_stage_wait_ctrl.sv
// MEM pipeline stage with a built-in MEM->WB register and a multi-cycle data memory.
// Memory operations stall upstream through 'ready'. WB receives bubbles until the access completes.
module mem_stage_wait_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_read_en_in,
    input  logic              mem_write_en_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [3:0]        dest_in,
    output logic              ready,
    output logic              addr_err,
    output logic              wb_en_out,
    output logic              mem_read_en_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [3:0]        dest_out
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] load_buf_q, load_buf_d;
    logic              wb_en_q, wb_en_d;
    logic              mem_read_en_q, mem_read_en_d;
    logic [DATA_W-1:0] alu_res_q, alu_res_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [3:0]        dest_q, dest_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic              is_store;
    logic              is_load;
    logic              addr_ok;
    logic              commit;
    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] idx_full;
    logic [IDX_W-1:0]  idx;

    // A store wins when both enables are set, so a load is a read without a write.
    always_comb begin
        req      = mem_read_en_in | mem_write_en_in;
        is_store = mem_write_en_in;
        is_load  = mem_read_en_in & ~mem_write_en_in;
        offset   = alu_res_in - DATA_W'(BASE_ADDR);
        idx_full = offset >> 2;
        idx      = idx_full[IDX_W-1:0];
        addr_ok  = (alu_res_in >= DATA_W'(BASE_ADDR)) &&
                   (alu_res_in[1:0] == 2'b00) &&
                   (idx_full < DATA_W'(DEPTH));
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_err_d    = addr_err_q;
        load_buf_d    = load_buf_q;
        ready         = 1'b0;
        commit        = 1'b0;
        wb_en_d       = 1'b0;
        mem_read_en_d = 1'b0;
        alu_res_d     = alu_res_q;
        mem_data_d    = mem_data_q;
        dest_d        = dest_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                    if (!addr_ok) begin
                        addr_err_d = 1'b1;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    commit     = 1'b1;
                    state_d    = DONE;
                    load_buf_d = addr_ok ? mem[idx] : '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Only a load leaving DONE carries memory data; every other capture writes zero.
        if (ready) begin
            wb_en_d       = wb_en_in;
            mem_read_en_d = is_load;
            alu_res_d     = alu_res_in;
            dest_d        = dest_in;
            mem_data_d    = (is_load && state_q == DONE) ? load_buf_q : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            addr_err_q    <= 1'b0;
            load_buf_q    <= '0;
            wb_en_q       <= 1'b0;
            mem_read_en_q <= 1'b0;
            alu_res_q     <= '0;
            mem_data_q    <= '0;
            dest_q        <= 4'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_err_q    <= addr_err_d;
            load_buf_q    <= load_buf_d;
            wb_en_q       <= wb_en_d;
            mem_read_en_q <= mem_read_en_d;
            alu_res_q     <= alu_res_d;
            mem_data_q    <= mem_data_d;
            dest_q        <= dest_d;
        end
    end

    // The array is never cleared. Reset only blocks a commit that would land on the same edge.
    always_ff @(posedge clk) begin
        if (!rst && commit && is_store && addr_ok) begin
            mem[idx] <= val_rm_in;
        end
    end

    assign addr_err        = addr_err_q;
    assign wb_en_out       = wb_en_q;
    assign mem_read_en_out = mem_read_en_q;
    assign alu_res_out     = alu_res_q;
    assign mem_data_out    = mem_data_q;
    assign dest_out        = dest_q;

endmodule
